// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision add/sub post-add datapath.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int SIG_W = 28;
   localparam int BIAS  = 127;
   localparam logic [EXP_W-1:0] EXP_INF = EXP_W'(2 * BIAS + 1);

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RDN = 2'b10,
      RM_RUP = 2'b11
   } rm_e;

   // Normalised beat handed from S1 to S2; exp is 9 bits so a carry past 255 stays visible.
   typedef struct packed {
      logic           sign;
      logic [EXP_W:0] exp;
      logic [MAN_W:0] sig;
      logic           g;
      logic           r;
      logic           s;
      logic           zero;
      rm_e            rm;
   } s1_t;

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter over the 27-bit sum below the carry bit.
module norm_lzc
   import fp_pkg::*;
(
   input  logic [SIG_W-2:0] vec,
   output logic [4:0]       count,
   output logic             all_zero
);

   logic found;

   always_comb begin
      // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
      count = '0;
      found = 1'b0;
      for (int i = SIG_W - 2; i >= 0; i--) begin
         if (vec[i]) begin
            found = 1'b1;
         end else if (!found) begin
            count = count + 5'd1;
         end
      end
   end

   assign all_zero = ~found;

endmodule

// File: rtl/fp_norm_round.sv
// Normalise, round and pack the raw significand sum into an IEEE-754 single, two-stage valid/ready pipe.
// Define FPNR_ROUND_MODES_EN to add the in_rm port and RTZ/RDN/RUP; otherwise round-to-nearest-even only.
module fp_norm_round
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic             in_op,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [SIG_W-1:0] in_sig,
`ifdef FPNR_ROUND_MODES_EN
   input  logic [1:0]       in_rm,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_overflow,
   output logic             out_underflow,
   output logic             out_inexact
);

   localparam logic [EXP_W:0]   EXP_ONE = (EXP_W+1)'(1);
   localparam logic [EXP_W-1:0] EXP_MAX = EXP_INF - EXP_W'(1);

   logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic        s2_ready;
   s1_t         s1_q, s1_d, norm;
   logic [31:0] result_q, result_d;
   logic        overflow_q, overflow_d, underflow_q, underflow_d, inexact_q, inexact_d;

   assign s2_ready = ~s2_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | s2_ready;

   // ---------------- S1: normalise ----------------
   logic [4:0]       lz, sh;
   logic             lz_all_zero;
   logic [EXP_W:0]   eff_exp, max_sh;
   logic [SIG_W-2:0] shifted;
   rm_e              rm;

   norm_lzc u_lzc (
      .vec      (in_sig[SIG_W-2:0]),
      .count    (lz),
      .all_zero (lz_all_zero)
   );

   always_comb begin
`ifdef FPNR_ROUND_MODES_EN
      rm = rm_e'(in_rm);
`else
      rm = RM_RNE;
`endif
      eff_exp = (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
      max_sh  = eff_exp - EXP_ONE;
      // Left shift stops at exponent 1; whatever remains below the hidden bit is denormal.
      sh      = ({{(EXP_W-4){1'b0}}, lz} > max_sh) ? max_sh[4:0] : lz;

      norm      = '0;
      norm.sign = in_sign;
      norm.rm   = rm;
      if (in_sig[SIG_W-1]) begin
         shifted  = {in_sig[SIG_W-1:2], in_sig[1] | in_sig[0]};
         norm.exp = eff_exp + EXP_ONE;
      end else begin
         shifted  = in_sig[SIG_W-2:0] << sh;
         norm.exp = shifted[SIG_W-2] ? eff_exp - {{(EXP_W-4){1'b0}}, sh} : '0;
      end
      norm.sig = shifted[SIG_W-2:3];
      norm.g   = shifted[2];
      norm.r   = shifted[1];
      norm.s   = shifted[0];
      if (~in_sig[SIG_W-1] & lz_all_zero) begin
         norm.zero = 1'b1;
         norm.sign = in_op ? (rm == RM_RDN) : in_sign;
      end

      s1_valid_d = in_ready ? in_valid : s1_valid_q;
      s1_d       = (in_ready & in_valid) ? norm : s1_q;
   end

   // ---------------- S2: round and pack ----------------
   logic             lost, round_up, sat;
   logic [MAN_W+1:0] sum;
   logic [EXP_W:0]   exp_r;
   logic [31:0]      pack_result;
   logic             pack_ovf, pack_unf, pack_inx;

   always_comb begin
      lost = s1_q.g | s1_q.r | s1_q.s;
      case (s1_q.rm)
         RM_RTZ:  round_up = 1'b0;
         RM_RDN:  round_up = lost & s1_q.sign;
         RM_RUP:  round_up = lost & ~s1_q.sign;
         default: round_up = s1_q.g & (s1_q.r | s1_q.s | s1_q.sig[0]);
      endcase
      sat = (s1_q.rm == RM_RTZ) | ((s1_q.rm == RM_RDN) & ~s1_q.sign)
          | ((s1_q.rm == RM_RUP) & s1_q.sign);

      sum = {1'b0, s1_q.sig} + {{(MAN_W+1){1'b0}}, round_up};
      // A denormal that rounds into the hidden bit lands exactly on exponent field 1.
      if (s1_q.exp == '0) exp_r = {{EXP_W{1'b0}}, sum[MAN_W]};
      else                exp_r = s1_q.exp + {{EXP_W{1'b0}}, sum[MAN_W+1]};

      pack_result = {s1_q.sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
      pack_ovf    = 1'b0;
      pack_unf    = lost & (s1_q.exp == '0);
      pack_inx    = lost;
      if (s1_q.zero) begin
         pack_result = {s1_q.sign, 31'd0};
         pack_unf    = 1'b0;
         pack_inx    = 1'b0;
      end else if (exp_r >= {1'b0, EXP_INF}) begin
         pack_result = sat ? {s1_q.sign, EXP_MAX, {MAN_W{1'b1}}}
                           : {s1_q.sign, EXP_INF, {MAN_W{1'b0}}};
         pack_ovf    = 1'b1;
         pack_unf    = 1'b0;
         pack_inx    = 1'b1;
      end

      s2_valid_d  = s2_ready ? s1_valid_q : s2_valid_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      inexact_d   = inexact_q;
      if (s2_ready & s1_valid_q) begin
         result_d    = pack_result;
         overflow_d  = pack_ovf;
         underflow_d = pack_unf;
         inexact_d   = pack_inx;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         inexact_q   <= inexact_d;
      end
   end

   // NOTE: the S1 payload is only ever read under s1_valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
   end

   assign out_valid     = s2_valid_q;
   assign out_result    = result_q;
   assign out_overflow  = overflow_q;
   assign out_underflow = underflow_q;
   assign out_inexact   = inexact_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vectors, backpressure and reset sequences, random vs reference model.
module tb_fp_norm_round;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sign, in_op;
   logic [7:0]  in_exp;
   logic [27:0] in_sig;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_inexact;

   fp_norm_round dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_op         (in_op),
      .in_exp        (in_exp),
      .in_sig        (in_sig),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_inexact   (out_inexact)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] result;
      logic        ovf;
      logic        unf;
      logic        inx;
   } res_t;

   typedef struct {
      string       name;
      logic        sign;
      logic        op;
      logic [7:0]  exp;
      logic [27:0] sig;
      res_t        want;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];
   res_t exp_q[$];

   task automatic check(string name, logic [63:0] actual, logic [63:0] want);
      checks++;
      if (actual !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, want);
      end
   endtask

   function automatic res_t dut_res();
      return '{out_result, out_overflow, out_underflow, out_inexact};
   endfunction

   function automatic vec_t mk(string n, logic s, logic o, logic [7:0] e, logic [27:0] g,
                               logic [31:0] r, logic ov, logic un, logic ix);
      vec_t v;
      v.name = n; v.sign = s; v.op = o; v.exp = e; v.sig = g;
      v.want = '{r, ov, un, ix};
      return v;
   endfunction

   // Reference: value-level normalise/round straight from the arithmetic rules.
   function automatic res_t ref_model(logic sign, logic op, logic [7:0] exp_in, logic [27:0] sig_in);
      res_t   r;
      longint m, keep;
      int     e, grs, field;
      bit     denorm, up, lost;
      r = '0;
      if (sig_in == 0) begin
         r.result = {(op ? 1'b0 : sign), 31'd0};
         return r;
      end
      e = (exp_in == 0) ? 1 : int'(exp_in);
      m = longint'(sig_in);
      if (m >= (longint'(1) << 27)) begin
         m = (m >> 1) | (m & 1);
         e++;
      end else begin
         while (m < (longint'(1) << 26) && e > 1) begin
            m = m * 2;
            e--;
         end
      end
      denorm = (m < (longint'(1) << 26));
      keep   = m >> 3;
      grs    = int'(m % 8);
      lost   = (grs != 0);
      up     = (grs >= 4) && ((grs % 4) != 0 || (keep % 2) == 1);
      keep   = keep + longint'(up);
      if (denorm) begin
         field = (keep >= (longint'(1) << 23)) ? 1 : 0;
      end else if (keep >= (longint'(1) << 24)) begin
         field = e + 1;
         keep  = keep >> 1;
      end else begin
         field = e;
      end
      if (field >= 255) begin
         r.result = {sign, 8'hFF, 23'd0};
         r.ovf    = 1'b1;
         r.inx    = 1'b1;
      end else begin
         r.result = {sign, 8'(field), 23'(keep)};
         r.inx    = lost;
         r.unf    = lost && denorm;
      end
      return r;
   endfunction

   task automatic apply(vec_t v);
      in_sign = v.sign;
      in_op   = v.op;
      in_exp  = v.exp;
      in_sig  = v.sig;
   endtask

   task automatic run_vec(vec_t v);
      apply(v);
      in_valid = 1'b1;
      @(negedge clk);
      check({v.name, "_accept"}, 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check({v.name, "_early_valid"}, 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check({v.name, "_valid"}, 64'(out_valid), 64'(1));
      check({v.name, "_result"}, 64'(dut_res()), 64'(v.want));
      @(posedge clk); #1;
   endtask

   task automatic rand_fields();
      int sel;
      in_sign = 1'($urandom_range(0, 1));
      in_op   = 1'($urandom_range(0, 1));
      sel     = $urandom_range(0, 7);
      case (sel)
         0:       in_exp = 8'd0;
         1:       in_exp = 8'd1;
         2:       in_exp = 8'd254;
         3:       in_exp = 8'd255;
         4:       in_exp = 8'($urandom_range(2, 30));
         default: in_exp = 8'($urandom_range(0, 255));
      endcase
      in_sig = 28'($urandom()) >> $urandom_range(0, 27);
      if ($urandom_range(0, 19) == 0) in_sig = '0;
   endtask

   task automatic sample_scb();
      res_t want;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_unexpected_output: got 0x%0h, expected no output", out_result);
         end else begin
            want = exp_q.pop_front();
            check("rand_result", 64'(dut_res()), 64'(want));
         end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_sign, in_op, in_exp, in_sig));
   endtask

   initial begin
      vec_t b[3];
      bit   ir_want[5] = '{1, 1, 0, 0, 1};
      bit   ov_want[8] = '{0, 0, 1, 1, 1, 1, 1, 0};
      int   rs_idx[8]  = '{-1, -1, 0, 0, 0, 1, 2, -1};
      int   nxt;
      bit   pending;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_sign = 1'b0; in_op = 1'b0; in_exp = '0; in_sig = '0;

      vecs.push_back(mk("one_plus_one",  0, 0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 0));
      vecs.push_back(mk("cancel",        0, 1, 8'd127, 28'h0000004, 32'h33800000, 0, 0, 0));
      vecs.push_back(mk("tie_even",      0, 0, 8'd127, 28'h4000004, 32'h3F800000, 0, 0, 1));
      vecs.push_back(mk("tie_up",        0, 0, 8'd127, 28'h400000C, 32'h3F800002, 0, 0, 1));
      vecs.push_back(mk("overflow",      0, 0, 8'd254, 28'h8000000, 32'h7F800000, 1, 0, 1));
      vecs.push_back(mk("zero_sub",      1, 1, 8'd127, 28'h0000000, 32'h00000000, 0, 0, 0));
      vecs.push_back(mk("denorm",        0, 0, 8'd1,   28'h2000000, 32'h00400000, 0, 0, 0));
      vecs.push_back(mk("neg_ovf",       1, 0, 8'd255, 28'h4000000, 32'hFF800000, 1, 0, 1));
      vecs.push_back(mk("round_carry",   0, 0, 8'd127, 28'h7FFFFFC, 32'h40000000, 0, 0, 1));
      vecs.push_back(mk("den_to_norm",   0, 0, 8'd0,   28'h3FFFFFC, 32'h00800000, 0, 1, 1));
      vecs.push_back(mk("den_tiny",      0, 0, 8'd0,   28'h0000006, 32'h00000001, 0, 1, 1));
      vecs.push_back(mk("zero_add_neg",  1, 0, 8'd5,   28'h0000000, 32'h80000000, 0, 0, 0));
      vecs.push_back(mk("partial_norm",  0, 0, 8'd3,   28'h0000010, 32'h00000008, 0, 0, 0));
      vecs.push_back(mk("sticky_only",   0, 0, 8'd127, 28'h4000001, 32'h3F800000, 0, 0, 1));
      vecs.push_back(mk("carry_sticky",  0, 0, 8'd100, 28'h8000009, 32'h32800001, 0, 0, 1));

      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_outputs", 64'(dut_res()), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(1));
      rst_n     = 1'b1;
      out_ready = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: downstream stalls for 4 cycles while 3 beats are offered.
      b[0] = vecs[0]; b[1] = vecs[2]; b[2] = vecs[3];
      nxt = 0;
      for (int c = 0; c < 8; c++) begin
         out_ready = (c >= 4);
         if (nxt < 3) begin
            apply(b[nxt]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (c < 5) check($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'(ir_want[c]));
         check($sformatf("bp_out_valid_c%0d", c), 64'(out_valid), 64'(ov_want[c]));
         if (rs_idx[c] >= 0)
            check($sformatf("bp_result_c%0d", c), 64'(dut_res()), 64'(b[rs_idx[c]].want));
         if (in_valid && in_ready) nxt++;
         @(posedge clk); #1;
      end

      // Random traffic with random stalls against the reference model.
      pending = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!pending) begin
            in_valid = ($urandom_range(0, 9) < 7);
            rand_fields();
         end
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         sample_scb();
         pending = in_valid && !in_ready;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         sample_scb();
         @(posedge clk); #1;
      end
      check("rand_drain_empty", 64'(exp_q.size()), 64'(0));

      // Reset with beats in flight: everything is dropped.
      for (int c = 0; c < 3; c++) begin
         apply(vecs[c]);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      check("rst_pre_valid", 64'(out_valid), 64'(1));
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_valid", 64'(out_valid), 64'(0));
      check("rst_mid_outputs", 64'(dut_res()), 64'(0));
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("rst_no_stale_c%0d", c), 64'(out_valid), 64'(0));
         @(posedge clk); #1;
      end
      run_vec(vecs[4]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-add stage of the FP add/sub datapath. It consumes the raw 28-bit significand sum from the adder, together with the sign and the larger exponent produced by the alignment stage.
- It normalises the sum (carry right-shift or leading-zero left-shift), rounds with guard/round/sticky bits, detects overflow and underflow, and packs an IEEE-754 single result.
- Two-stage valid/ready pipeline; sits between the significand adder and the result writeback.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width
- SIG_W, 28, input significand width: {carry, hidden, MAN_W mantissa, g, r, s}

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_sign  in  1  result sign from alignment
- in_op  in  1  effective operation; 1 = subtract
- in_exp  in  8  larger biased exponent (0 = denormal operand)
- in_sig  in  28  adder sum; bit26 = weight 2^0, bits[2:0] = g,r,s
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  packed single
- out_overflow  out  1  result rounded to infinity
- out_underflow  out  1  tiny and inexact
- out_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset (rst_n low at a clk edge): s1_valid = s2_valid = 0; out_valid = 0; out_result = 0; all flags 0. This applies mid-operation; in-flight beats are dropped.
- Handshake:
  - A transfer occurs on a cycle with valid & ready.
  - S2 advances when ~s2_valid | out_ready.
  - S1 advances when ~s1_valid | s2 accepting.
  - in_ready = ~s1_valid | s1 moving to s2.
  - Full throughput: one beat per cycle, latency exactly 2 cycles from input acceptance to out_valid.
  - Outputs are held stable while out_valid & ~out_ready. Beats are never lost or reordered.
- S1 (normalise), registered:
  - eff_exp = (in_exp == 0) ? 1 : in_exp, using 9-bit unsigned arithmetic.
  - Carry case, in_sig[27] = 1: sig >> 1, sticky |= shifted-out bit, exp = eff_exp + 1.
  - Zero case, in_sig == 0: zero flag set. Sign = in_op ? 0 : in_sign.
  - Otherwise: lz = leading zeros of in_sig[26:0]. sh = min(lz, eff_exp - 1); sig << sh; exp = eff_exp - sh.
  - After the shift, if bit26 == 0 the result is denormal and its exp field is 0.
- S2 (round and pack):
  - Round to nearest even: round_up = g & (r | s | lsb).
  - inexact = g | r | s.
  - If the mantissa increment carries out of 24 bits: exp + 1, significand = 1.0.
  - A denormal that rounds into bit 23 becomes exp field 1.
  - If exp >= 255: result = {sign, 8'hFF, 23'd0}, overflow = 1, inexact = 1.
  - underflow = inexact & (pre-round exp field == 0).
  - A zero result is exact, with all flags 0.

Optional Feature:
- Macro: FPNR_ROUND_MODES_EN.
- When defined:
  - Adds port in_rm (in, 2 bits), captured with each beat. Encoding: 00 = RNE, 01 = RTZ, 10 = RDN, 11 = RUP.
  - RTZ never rounds up.
  - RDN/RUP round up the magnitude when inexact and the sign is 1/0 respectively.
  - On overflow, RTZ (and RDN for positive, RUP for negative) yields 0x7F7FFFFF with the appropriate sign instead of infinity.
  - Exact zero from subtraction gets sign 1 under RDN.
- When undefined: no in_rm port; RNE only.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, MAN_W, SIG_W, BIAS = 127, EXP_INF = 8'hFF
  - rounding-mode enum (RM_RNE/RM_RTZ/RM_RDN/RM_RUP)
  - S1→S2 pipeline struct: sign, exp[8:0], sig[23:0], g, r, s, zero, rm
- One sub-module, norm_lzc: combinational 27-bit leading-zero counter, 5-bit count, all-zero flag.

Test Plan:
- 1.0+1.0: in_exp=127, in_sig=28'h8000000, op=0 → after 2 cycles out_result=0x40000000, flags 0.
- Cancellation: in_exp=127, in_sig=28'h0000004, op=1 → 0x33800000, inexact=0.
- Ties:
  - in_exp=127, in_sig=28'h4000004 → 0x3F800000, inexact=1 (tie to even).
  - in_sig=28'h400000C → 0x3F800002, inexact=1.
- Overflow/zero/denormal:
  - in_exp=254, in_sig=28'h8000000 → 0x7F800000, overflow=1, inexact=1.
  - in_sig=0, op=1, sign=1 → 0x00000000.
  - in_exp=1, in_sig=28'h2000000 → 0x00400000, underflow=0.
- Backpressure/reset:
  - out_ready=0 for 4 cycles with 3 beats offered → in_ready falls after 2 accepts; release yields the 3 results in order, one per cycle.
  - rst_n=0 mid-stream → out_valid=0 next cycle, no stale output afterward.
